// File: rtl/gate_manager_param.sv
// gate_manager_param: parking-gate controller with PIN retries, open timeout, lockout and admitted-vehicle count.
// Optional GATE_AUDIT_EN adds the lock_events counter and last_lock_cause outputs.
`default_nettype none

module gate_manager_param #(
    parameter int               PIN_W        = 16,
    parameter logic [PIN_W-1:0] RIGHT_PIN    = 16'h2468,
    parameter logic [PIN_W-1:0] UNLOCK_PIN   = 16'hA5A5,
    parameter int               MAX_TRIES    = 3,
    parameter int               OPEN_TIMEOUT = 255,
    parameter int               CAR_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s01,
    input  logic             s02,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin,
    output logic             gate,
    output logic             wrong_pin_alarm,
    output logic             lock_alarm,
    output logic [3:0]       tries,
`ifdef GATE_AUDIT_EN
    output logic [CAR_W-1:0] car_count,
    output logic [7:0]       lock_events,
    output logic [1:0]       last_lock_cause
`else
    output logic [CAR_W-1:0] car_count
`endif
);

    localparam int                 TIMER_W    = $clog2(OPEN_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(OPEN_TIMEOUT - 1);
    localparam logic [3:0]         TRIES_MAX  = 4'(MAX_TRIES);

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        WAIT_PIN = 4'b0010,
        OPEN     = 4'b0100,
        BLOCKED  = 4'b1000
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [3:0]         tries_nx;
    logic               wrong_nx;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nx;
    logic [CAR_W-1:0]   car_nx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            tries           <= 4'd0;
            wrong_pin_alarm <= 1'b0;
            timer           <= '0;
            car_count       <= '0;
        end else begin
            state           <= state_nx;
            tries           <= tries_nx;
            wrong_pin_alarm <= wrong_nx;
            timer           <= timer_nx;
            car_count       <= car_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tries_nx = tries;
        wrong_nx = wrong_pin_alarm;
        timer_nx = timer;
        car_nx   = car_count;
        case (state)
            IDLE: begin
                if (s01 && s02) begin
                    state_nx = BLOCKED;
                end else if (s01) begin
                    state_nx = WAIT_PIN;
                end
            end
            WAIT_PIN: begin
                if (s02) begin
                    state_nx = BLOCKED;
                end else if (pin_valid && (pin == RIGHT_PIN)) begin
                    state_nx = OPEN;
                    tries_nx = 4'd0;
                    wrong_nx = 1'b0;
                    timer_nx = '0;
                end else if (pin_valid) begin
                    tries_nx = tries + 4'd1;
                    wrong_nx = 1'b1;
                    if (tries_nx == TRIES_MAX) begin
                        state_nx = BLOCKED;
                    end
                end else if (!s01) begin
                    // tries/alarm deliberately survive the vehicle leaving
                    state_nx = IDLE;
                end
            end
            OPEN: begin
                timer_nx = timer + 1'b1;
                if (s02) begin
                    state_nx = IDLE;
                    if (car_count != '1) begin
                        car_nx = car_count + 1'b1;
                    end
                end else if (timer == TIMER_LAST) begin
                    state_nx = IDLE;
                end
            end
            BLOCKED: begin
                if (pin_valid && (pin == UNLOCK_PIN)) begin
                    state_nx = IDLE;
                    tries_nx = 4'd0;
                    wrong_nx = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign gate       = (state == OPEN);
    assign lock_alarm = (state == BLOCKED);

`ifdef GATE_AUDIT_EN
    logic       lock_entry;
    logic [1:0] lock_cause;

    assign lock_entry = (state != BLOCKED) && (state_nx == BLOCKED);
    // Only IDLE and WAIT_PIN can enter BLOCKED; in WAIT_PIN a crossing outranks retries
    assign lock_cause = (state == IDLE) ? 2'b01 : (s02 ? 2'b10 : 2'b11);

    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_events     <= 8'd0;
            last_lock_cause <= 2'b00;
        end else if (lock_entry) begin
            last_lock_cause <= lock_cause;
            if (lock_events != 8'hFF) begin
                lock_events <= lock_events + 8'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_gate_manager_param.sv
// Self-checking bench for gate_manager_param: reference model compared every cycle plus directed literal checks.
`default_nettype none

module tb_gate_manager_param;

    localparam int          PIN_W   = 16;
    localparam logic [15:0] RIGHT   = 16'h2468;
    localparam logic [15:0] UNLOCK  = 16'hA5A5;
    localparam int          MAXT    = 3;
    localparam int          TIMEOUT = 4;
    localparam int          CAR_W   = 2;
    localparam int          CAR_MAX = (1 << CAR_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             s01 = 1'b0;
    logic             s02 = 1'b0;
    logic             pin_valid = 1'b0;
    logic [PIN_W-1:0] pin = '0;
    logic             gate;
    logic             wrong_pin_alarm;
    logic             lock_alarm;
    logic [3:0]       tries;
    logic [CAR_W-1:0] car_count;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    gate_manager_param #(
        .PIN_W(PIN_W), .RIGHT_PIN(RIGHT), .UNLOCK_PIN(UNLOCK),
        .MAX_TRIES(MAXT), .OPEN_TIMEOUT(TIMEOUT), .CAR_W(CAR_W)
    ) dut (
        .clk(clk), .rst(rst), .s01(s01), .s02(s02),
        .pin_valid(pin_valid), .pin(pin),
        .gate(gate), .wrong_pin_alarm(wrong_pin_alarm), .lock_alarm(lock_alarm),
        .tries(tries), .car_count(car_count)
    );

    always #5 clk = ~clk;

    // Reference model: mode name, remaining open cycles, plain integer counters
    string m_mode = "IDLE";
    int    m_tries = 0;
    int    m_wrong = 0;
    int    m_cars  = 0;
    int    m_left  = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_mode = "IDLE"; m_tries = 0; m_wrong = 0; m_cars = 0; m_left = 0;
        end else if (m_mode == "IDLE") begin
            if (s01 && s02) m_mode = "BLOCKED";
            else if (s01)   m_mode = "WAIT_PIN";
        end else if (m_mode == "WAIT_PIN") begin
            if (s02) m_mode = "BLOCKED";
            else if (pin_valid && pin == RIGHT) begin
                m_mode = "OPEN"; m_tries = 0; m_wrong = 0; m_left = TIMEOUT;
            end else if (pin_valid) begin
                m_tries++; m_wrong = 1;
                if (m_tries == MAXT) m_mode = "BLOCKED";
            end else if (!s01) m_mode = "IDLE";
        end else if (m_mode == "OPEN") begin
            if (s02) begin
                m_mode = "IDLE";
                m_cars = (m_cars == CAR_MAX) ? CAR_MAX : m_cars + 1;
            end else begin
                m_left--;
                if (m_left == 0) m_mode = "IDLE";
            end
        end else begin
            if (pin_valid && pin == UNLOCK) begin
                m_mode = "IDLE"; m_tries = 0; m_wrong = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_gate",  int'(gate),            int'(m_mode == "OPEN"));
            check("model_lock",  int'(lock_alarm),      int'(m_mode == "BLOCKED"));
            check("model_wrong", int'(wrong_pin_alarm), m_wrong);
            check("model_tries", int'(tries),           m_tries);
            check("model_cars",  int'(car_count),       m_cars);
        end
    end

    // Apply one cycle of inputs; outputs reflecting them are visible on return
    task automatic cyc(input logic a, input logic b, input logic v, input logic [15:0] p);
        s01 = a; s02 = b; pin_valid = v; pin = p;
        @(negedge clk);
    endtask

    task automatic idle1();
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic admit();
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 1'b1, RIGHT);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_gate", int'(gate), 0);
        check("reset_cars", int'(car_count), 0);
        rst = 1'b1;
        chk_en = 1'b1;

        // Reset while OPEN
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 1'b1, RIGHT);
        check("open_before_reset", int'(gate), 1);
        rst = 1'b0;
        idle1(); idle1();
        check("rst_gate", int'(gate), 0);
        check("rst_lock", int'(lock_alarm), 0);
        check("rst_tries", int'(tries), 0);
        rst = 1'b1;

        // Normal admission
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("wait_gate", int'(gate), 0);
        cyc(1'b1, 1'b0, 1'b1, RIGHT);
        check("pin_gate", int'(gate), 1);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        check("pass_gate", int'(gate), 0);
        check("pass_cars", int'(car_count), 1);
        idle1();

        // Wrong PINs held over consecutive cycles, then retries exhausted
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 1'b1, 16'h1111);
        check("try1", int'(tries), 1);
        check("try1_alarm", int'(wrong_pin_alarm), 1);
        cyc(1'b1, 1'b0, 1'b1, 16'h2222);
        check("try2", int'(tries), 2);
        check("try2_lock", int'(lock_alarm), 0);
        cyc(1'b1, 1'b0, 1'b1, 16'h3333);
        check("try3_lock", int'(lock_alarm), 1);
        check("try3_gate", int'(gate), 0);

        // BLOCKED ignores right PIN and sensors; unlock clears
        cyc(1'b0, 1'b0, 1'b1, RIGHT);
        check("blk_right_pin", int'(lock_alarm), 1);
        check("blk_tries_kept", int'(tries), 3);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        check("blk_sensors", int'(lock_alarm), 1);
        cyc(1'b0, 1'b0, 1'b1, UNLOCK);
        check("unlock_lock", int'(lock_alarm), 0);
        check("unlock_tries", int'(tries), 0);
        check("unlock_alarm", int'(wrong_pin_alarm), 0);

        // Tries and alarm survive the vehicle leaving
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 1'b1, 16'h0001);
        idle1();
        check("left_tries", int'(tries), 1);
        check("left_alarm", int'(wrong_pin_alarm), 1);

        // Timeout: gate high exactly TIMEOUT cycles, no count
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 1'b1, RIGHT);
        check("to_clear_tries", int'(tries), 0);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            idle1();
            check("to_gate_high", int'(gate), 1);
        end
        idle1();
        check("to_gate_low", int'(gate), 0);
        check("to_no_count", int'(car_count), 1);

        // Passage on the last open cycle wins over timeout
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 1'b1, RIGHT);
        for (int i = 0; i < TIMEOUT - 1; i++) idle1();
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        check("last_cycle_count", int'(car_count), 2);

        // Tailgate in IDLE
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        check("tailgate", int'(lock_alarm), 1);
        cyc(1'b0, 1'b0, 1'b1, UNLOCK);

        // Passage in WAIT_PIN outranks a right PIN
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 1'b1, 1'b1, RIGHT);
        check("wait_passage", int'(lock_alarm), 1);
        check("wait_passage_gate", int'(gate), 0);
        cyc(1'b0, 1'b0, 1'b1, UNLOCK);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            admit();
            idle1();
        end
        check("car_saturate", int'(car_count), 3);

        // Mixed traffic with occasional resets, checked by the model only
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [15:0] p;
            r = $urandom_range(0, 3);
            p = (r == 0) ? RIGHT : (r == 1) ? UNLOCK : 16'($urandom);
            rst = ($urandom_range(0, 79) != 0);
            cyc($urandom_range(0, 2) != 0, $urandom_range(0, 6) == 0,
                $urandom_range(0, 2) == 0, p);
        end
        rst = 1'b1;
        idle1();

        chk_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gate_manager_param.md
Name: gate_manager_param

Overview:
Parametrised second-generation parking-gate controller. Handles vehicle arrival and passage sensors, a strobed PIN entry with a configurable retry limit, and a gate-open timeout. Locks out on tailgating or when retries are exhausted; only an unlock PIN clears the lockout. Keeps a saturating count of vehicles admitted. Sits between the sensor/keypad front end and the gate actuator/alarm drivers.

Parameters:
PIN_W, 16, PIN width in bits
RIGHT_PIN, 16'h2468, user PIN that opens the gate (PIN_W bits)
UNLOCK_PIN, 16'hA5A5, supervisor PIN that clears BLOCKED (PIN_W bits; must differ from RIGHT_PIN)
MAX_TRIES, 3, wrong PINs per vehicle session that cause BLOCKED (1..15)
OPEN_TIMEOUT, 255, max cycles the gate stays open without passage (>=1)
CAR_W, 8, width of vehicle counter

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-low (0 at posedge resets)
s01  in  1  arrival sensor, vehicle present at gate
s02  in  1  passage sensor, vehicle crossing gate line
pin_valid  in  1  one-cycle strobe, pin is sampled this cycle
pin  in  PIN_W  entered PIN
gate  out  1  gate open command
wrong_pin_alarm  out  1  wrong PIN registered since last clear
lock_alarm  out  1  controller is BLOCKED
tries  out  4  wrong PINs in current session
car_count  out  CAR_W  vehicles admitted, saturating

Behaviour:
- Reset (rst==0 at posedge): state IDLE; tries=0, timer=0, car_count=0. All outputs 0 in the following cycle. Reset wins over every other event, in any state.
- States are IDLE, WAIT_PIN, OPEN and BLOCKED, in one-hot registers. An illegal encoding goes to IDLE next cycle.
- Outputs are Moore/registered: gate=(state==OPEN); lock_alarm=(state==BLOCKED); wrong_pin_alarm, tries and car_count are registers.
- IDLE:
  - s01&&s02 -> BLOCKED (tailgate).
  - s01&&!s02 -> WAIT_PIN.
  - Otherwise stay. pin_valid is ignored.
- WAIT_PIN, checked in this priority order:
  1. s02=1 -> BLOCKED (crossing without authorisation).
  2. pin_valid && pin==RIGHT_PIN -> OPEN; tries=0; wrong_pin_alarm=0; timer=0.
  3. pin_valid && wrong pin -> tries+1 and wrong_pin_alarm=1. If tries+1==MAX_TRIES, go to BLOCKED; otherwise stay.
  4. s01=0 (vehicle left) -> IDLE. tries and wrong_pin_alarm are kept; they are cleared only by the right PIN, the unlock PIN or reset.
- OPEN:
  - gate=1; timer increments each cycle.
  - s02=1 -> IDLE; car_count+1, saturating at all-ones.
  - timer==OPEN_TIMEOUT-1 with no s02 -> IDLE; no count.
  - s02 and timeout in the same cycle: s02 wins and the vehicle is counted.
  - s01 and pin_valid are ignored.
- BLOCKED:
  - lock_alarm=1; sensors are ignored.
  - pin_valid && pin==UNLOCK_PIN -> IDLE; tries=0; wrong_pin_alarm=0.
  - Any other PIN is ignored and does not change tries.
- Timing:
  - Every transition takes effect at the posedge where its conditions are sampled.
  - Outputs reflect the new state one cycle after stimulus.
  - pin_valid held high for N cycles counts as N entries.
- Width rules:
  - tries is 4 bits, with MAX_TRIES<=15.
  - The timer is sized with $clog2(OPEN_TIMEOUT+1).
  - Comparisons are full PIN_W-bit equality.

Optional Feature:
Macro GATE_AUDIT_EN.
- Defined:
  - Adds output port lock_events [7:0], counting entries into BLOCKED. It saturates at 8'hFF and is cleared only by reset.
  - Adds output last_lock_cause [1:0]: 01 tailgate in IDLE, 10 passage in WAIT_PIN, 11 retries exhausted. It is updated on BLOCKED entry and reset to 00.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
1. Reset held low 2 cycles during OPEN -> gate=0, lock_alarm=0, wrong_pin_alarm=0, tries=0, car_count=0; state IDLE.
2. s01=1, then pin=16'h2468 with pin_valid, then s02=1 pulse -> gate=1 one cycle after the PIN; gate=0 after s02; car_count 0->1.
3. s01=1, pins 16'h1111 and 16'h2222 -> tries=1 then 2, wrong_pin_alarm=1, still WAIT_PIN. Third pin 16'h3333 (MAX_TRIES=3) -> lock_alarm=1, gate=0.
4. BLOCKED: pin=16'h2468 -> stays BLOCKED. pin=16'hA5A5 -> IDLE, lock_alarm=0, tries=0, wrong_pin_alarm=0.
5. OPEN_TIMEOUT=4: right PIN with no s02 -> gate high exactly 4 cycles, then IDLE, car_count unchanged. s02 on the 4th cycle -> counted.
6. Tailgate and saturation:
   - IDLE with s01=s02=1 -> BLOCKED.
   - CAR_W=2, 5 admissions -> car_count sticks at 3.
